// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the core's fetch and data ports, one access at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_port_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic [XLEN-1:0] if_rdata,
   output logic            if_ack,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [XLEN-1:0] d_mask,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_ack,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [XLEN-1:0] mem_mask,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arbState_t;

   localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

   arbState_t       state, nextState;
   logic [7:0]      waitCnt;
   logic            grantData;
   logic            timedOut;
   logic            anyReq;
   logic            pickData;
   logic            memWe;
   logic [XLEN-1:0] memAddr, memWdata, memMask;
   logic [XLEN-1:0] ifRdata, dRdata;

   assign anyReq = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   logic lastGrant;  // 1 = data port was granted last

   always_ff @(posedge clk) begin
      if (!reset)
         lastGrant <= 1'b0;
      else if (state == IDLE && anyReq)
         lastGrant <= pickData;
   end

   // On a conflict the port that was not served last time wins.
   assign pickData = d_req & (~if_req | ~lastGrant);
`else
   // Data wins conflicts so a stalled memory stage can always drain.
   assign pickData = d_req;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // NOTE: nextState gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      nextState = state;
      case (state)
         IDLE:           if (anyReq) nextState = pickData ? BUSY_D : BUSY_I;
         BUSY_I, BUSY_D: if (mem_ack || waitCnt == TimeoutLimit) nextState = RESP;
         RESP:           nextState = IDLE;
         default:        nextState = IDLE;
      endcase
   end

   // NOTE: the latched request and read-data registers are reset too, since every output must read 0 in reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         grantData <= 1'b0;
         timedOut  <= 1'b0;
         waitCnt   <= '0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memWdata  <= '0;
         memMask   <= '0;
         ifRdata   <= '0;
         dRdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  grantData <= pickData;
                  timedOut  <= 1'b0;
                  waitCnt   <= '0;
                  memWe     <= pickData & d_we;
                  memAddr   <= pickData ? d_addr  : if_addr;
                  memWdata  <= pickData ? d_wdata : '0;
                  memMask   <= pickData ? d_mask  : '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack) begin
                  if (grantData) dRdata  <= mem_rdata;
                  else           ifRdata <= mem_rdata;
               end else if (waitCnt == TimeoutLimit) begin
                  timedOut <= 1'b1;
                  if (grantData) dRdata  <= '0;
                  else           ifRdata <= '0;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = (state == BUSY_I) || (state == BUSY_D);
   assign mem_we    = memWe;
   assign mem_addr  = memAddr;
   assign mem_wdata = memWdata;
   assign mem_mask  = memMask;
   assign if_ack    = (state == RESP) && !grantData;
   assign d_ack     = (state == RESP) &&  grantData;
   assign err       = (state == RESP) &&  timedOut;
   assign if_rdata  = ifRdata;
   assign d_rdata   = dRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level timeline model predicts grants, acks and data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int XLEN = 32;
   localparam int TO   = 15;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_req, if_ack, d_req, d_we, d_ack;
   logic [XLEN-1:0] if_addr, if_rdata, d_addr, d_wdata, d_mask, d_rdata;
   logic            mem_req, mem_we, mem_ack, err;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_mask, mem_rdata;

   mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
   );

   always #5 clk = ~clk;

   // One requester's access: raise time, memory delay (-1 = never acks), fields, returned data.
   typedef struct {
      logic        active;
      int          r;
      int          dly;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      logic [31:0] rdata;
      logic        dropEarly;
   } portReq_t;

   int          nChecks = 0;
   int          nFails  = 0;
   logic        mLastData = 1'b0;
   logic [31:0] holdIf = '0;
   logic [31:0] holdD  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic nextSample();
      @(posedge clk);
      #1;
   endtask

   function automatic logic arbPicksData();
`ifdef MEM_ARB_RR_EN
      return !mLastData;
`else
      return 1'b1;
`endif
   endfunction

   function automatic portReq_t idleReq();
      portReq_t p;
      p.active = 1'b0; p.r = 0; p.dly = 0; p.we = 1'b0;
      p.addr = '0; p.wdata = '0; p.mask = '0; p.rdata = '0; p.dropEarly = 1'b0;
      return p;
   endfunction

   function automatic int pickDelay();
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) return -1;
      if (sel == 1) return TO;
      return int'($urandom_range(0, 3));
   endfunction

   function automatic portReq_t randReq(input logic isData);
      portReq_t p;
      p.active    = ($urandom_range(0, 3) != 0);
      p.r         = int'($urandom_range(0, 2));
      p.dly       = pickDelay();
      p.we        = isData ? 1'($urandom_range(0, 1)) : 1'b0;
      p.addr      = $urandom();
      p.wdata     = $urandom();
      p.mask      = $urandom();
      p.rdata     = $urandom();
      p.dropEarly = ($urandom_range(0, 3) == 0);
      return p;
   endfunction

   // Predicts grant/ack samples from the arbitration rules, then drives and checks every sample.
   task automatic runEpisode(input portReq_t pI, input portReq_t pD, input int ep);
      int    gI, gD, aI, aD, bI, bD, g1, endS;
      logic  candI, candD, dFirst, busyI, busyD, reqI, reqD, ackNow, expErr;
      string pfx;
      gI = -1; gD = -1; aI = -1; aD = -1;
      bI = (pI.dly < 0) ? TO + 1 : pI.dly + 1;
      bD = (pD.dly < 0) ? TO + 1 : pD.dly + 1;
      if (pI.active && pD.active) begin
         g1    = ((pI.r < pD.r) ? pI.r : pD.r) + 1;
         candI = (pI.r <= g1 - 1);
         candD = (pD.r <= g1 - 1);
         dFirst = (candI && candD) ? arbPicksData() : candD;
         if (dFirst) begin
            gD = g1; aD = gD + bD;
            gI = (aD + 2 > pI.r + 1) ? aD + 2 : pI.r + 1; aI = gI + bI;
         end else begin
            gI = g1; aI = gI + bI;
            gD = (aI + 2 > pD.r + 1) ? aI + 2 : pD.r + 1; aD = gD + bD;
         end
         mLastData = ~dFirst;
      end else if (pI.active) begin
         gI = pI.r + 1; aI = gI + bI; mLastData = 1'b0;
      end else if (pD.active) begin
         gD = pD.r + 1; aD = gD + bD; mLastData = 1'b1;
      end
      endS = ((aI > aD) ? aI : aD) + 1;
      if (endS < 4) endS = 4;

      for (int i = 0; i <= endS; i++) begin
         pfx    = $sformatf("ep%0d.%0d", ep, i);
         busyI  = pI.active && i >= gI && i < aI;
         busyD  = pD.active && i >= gD && i < aD;
         check({pfx, " mem_req"}, 32'(mem_req), 32'(busyI | busyD));
         if (busyI) begin
            check({pfx, " mem_we(if)"},    32'(mem_we), 32'd0);
            check({pfx, " mem_addr(if)"},  mem_addr,    pI.addr);
            check({pfx, " mem_wdata(if)"}, mem_wdata,   32'd0);
            check({pfx, " mem_mask(if)"},  mem_mask,    32'd0);
         end
         if (busyD) begin
            check({pfx, " mem_we(d)"},    32'(mem_we), 32'(pD.we));
            check({pfx, " mem_addr(d)"},  mem_addr,    pD.addr);
            check({pfx, " mem_wdata(d)"}, mem_wdata,   pD.wdata);
            check({pfx, " mem_mask(d)"},  mem_mask,    pD.mask);
         end
         if (pI.active && i == aI) holdIf = (pI.dly < 0) ? 32'd0 : pI.rdata;
         if (pD.active && i == aD) holdD  = (pD.dly < 0) ? 32'd0 : pD.rdata;
         expErr = (pI.active && i == aI && pI.dly < 0) || (pD.active && i == aD && pD.dly < 0);
         check({pfx, " if_ack"},   32'(if_ack), 32'(pI.active && i == aI));
         check({pfx, " d_ack"},    32'(d_ack),  32'(pD.active && i == aD));
         check({pfx, " err"},      32'(err),    32'(expErr));
         check({pfx, " if_rdata"}, if_rdata,    holdIf);
         check({pfx, " d_rdata"},  d_rdata,     holdD);

         reqI = pI.active && i >= pI.r && i < (pI.dropEarly ? gI : aI);
         reqD = pD.active && i >= pD.r && i < (pD.dropEarly ? gD : aD);
         if_req  = reqI;
         if_addr = reqI ? pI.addr : $urandom();
         d_req   = reqD;
         d_we    = reqD ? pD.we    : 1'($urandom_range(0, 1));
         d_addr  = reqD ? pD.addr  : $urandom();
         d_wdata = reqD ? pD.wdata : $urandom();
         d_mask  = reqD ? pD.mask  : $urandom();
         ackNow  = (busyI && pI.dly >= 0 && i == gI + pI.dly) ||
                   (busyD && pD.dly >= 0 && i == gD + pD.dly);
         if (busyI || busyD) mem_ack = ackNow;
         else                mem_ack = ($urandom_range(0, 3) == 0);
         mem_rdata = ackNow ? (busyI ? pI.rdata : pD.rdata) : $urandom();
         nextSample();
      end
   endtask

   portReq_t pI, pD;

   initial begin
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; d_mask = '0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) nextSample();
      check("rst mem_req",   32'(mem_req), 32'd0);
      check("rst mem_we",    32'(mem_we),  32'd0);
      check("rst mem_addr",  mem_addr,     32'd0);
      check("rst mem_wdata", mem_wdata,    32'd0);
      check("rst mem_mask",  mem_mask,     32'd0);
      check("rst if_ack",    32'(if_ack),  32'd0);
      check("rst d_ack",     32'(d_ack),   32'd0);
      check("rst err",       32'(err),     32'd0);
      check("rst if_rdata",  if_rdata,     32'd0);
      check("rst d_rdata",   d_rdata,      32'd0);
      reset = 1'b1;

      // Fetch with a one-cycle memory.
      pI = idleReq(); pI.active = 1'b1; pI.addr = 32'h0000_0010; pI.rdata = 32'h0051_0113;
      runEpisode(pI, idleReq(), 0);

      // Two back-to-back conflicts with an immediate memory.
      pI = idleReq(); pI.active = 1'b1; pI.addr = 32'h0000_0100; pI.rdata = 32'h1111_2222;
      pD = idleReq(); pD.active = 1'b1; pD.addr = 32'h0000_0200; pD.rdata = 32'h3333_4444;
      runEpisode(pI, pD, 1);
      pI.addr = 32'h0000_0104; pI.rdata = 32'h5555_6666;
      pD.addr = 32'h0000_0204; pD.rdata = 32'h7777_8888;
      runEpisode(pI, pD, 2);

      // Store: exact fields must reach the memory bus.
      pD = idleReq(); pD.active = 1'b1; pD.dly = 1; pD.we = 1'b1; pD.addr = 32'h0000_0040;
      pD.wdata = 32'hDEAD_BEEF; pD.mask = 32'h0000_FFFF; pD.rdata = 32'hCAFE_F00D;
      runEpisode(idleReq(), pD, 3);

      // Timed-out load, then a fetch that queued behind it.
      pD = idleReq(); pD.active = 1'b1; pD.dly = -1; pD.addr = 32'h0000_0080;
      pI = idleReq(); pI.active = 1'b1; pI.r = 1; pI.addr = 32'h0000_0014; pI.rdata = 32'h00A0_0093;
      runEpisode(pI, pD, 4);

      // Ack on the last legal busy cycle beats the timeout.
      pI = idleReq(); pI.active = 1'b1; pI.dly = TO; pI.addr = 32'h0000_0018; pI.rdata = 32'h0BAD_0001;
      runEpisode(pI, idleReq(), 5);

      // No requests: stray memory acks must be ignored.
      runEpisode(idleReq(), idleReq(), 6);

      for (int ep = 7; ep < 160; ep++) begin
         pI = randReq(1'b0);
         pD = randReq(1'b1);
         runEpisode(pI, pD, ep);
      end

      // Reset in the middle of a data access.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_ack = 1'b0;
      nextSample();
      check("midrst busy", 32'(mem_req), 32'd1);
      nextSample();
      reset = 1'b0;
      nextSample();
      check("midrst mem_req", 32'(mem_req), 32'd0);
      check("midrst d_ack",   32'(d_ack),   32'd0);
      check("midrst d_rdata", d_rdata,      32'd0);
      check("midrst if_rdata", if_rdata,    32'd0);
      reset = 1'b1; d_req = 1'b0;
      holdIf = '0; holdD = '0; mLastData = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nextSample();
         check($sformatf("postrst%0d mem_req", i), 32'(mem_req), 32'd0);
         check($sformatf("postrst%0d d_ack", i),   32'(d_ack),   32'd0);
      end
      pI = idleReq(); pI.active = 1'b1; pI.dly = 2; pI.addr = 32'h0000_0020; pI.rdata = 32'h0020_0513;
      runEpisode(pI, idleReq(), 200);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
